// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: op encoding and default widths shared by the drawing engines
package mem_port_arbiter_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;
  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_e;
endpackage

// File: rtl/mem_port_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching rts upward from ptr with wrap
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  rts,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    // walk from farthest to nearest so the candidate closest to ptr wins
    for (int k = N - 1; k >= 0; k--)
      if (rts[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of the memory port; registered command,
// read data broadcast with a one-hot owner strobe RD_LAT+2 cycles after transfer
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_LAT  = 2
) (
  input  logic                        clk,
  input  logic                        rst_,
  input  logic [NUM_REQ-1:0]          req_rts,
  output logic [NUM_REQ-1:0]          req_rtr,
  input  logic [NUM_REQ-1:0]          req_op,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_wben,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [DATA_W/8-1:0]         mem_wben,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [DATA_W-1:0]           bcast_data,
  output logic [NUM_REQ-1:0]          bcast_xfc
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = DATA_W / 8;
  logic [IW-1:0] rr_ptr, win;
  logic [NUM_REQ-1:0] gnt;
  logic any, xfer, rd;
  // tag[k] is the owner of the read whose data arrives k cycles later on mem_rdata
  logic [NUM_REQ-1:0] tag [RD_LAT+1];
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .rts(req_rts),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(win),
    .any(any)
  );
  assign req_rtr = rst_ ? gnt : '0;
  assign xfer = |req_rtr;
  assign rd = req_op[win] == OP_READ;
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      rr_ptr <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wben <= '0;
      bcast_data <= '0;
      bcast_xfc <= '0;
      for (int k = 0; k <= RD_LAT; k++) tag[k] <= '0;
    end else begin
      mem_en <= xfer;
      if (xfer) begin
        rr_ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        mem_we <= req_op[win] == OP_WRITE;
        mem_addr <= req_addr[int'(win)*ADDR_W +: ADDR_W];
        mem_wdata <= req_data[int'(win)*DATA_W +: DATA_W];
        mem_wben <= req_wben[int'(win)*BW +: BW];
      end
      tag[0] <= (xfer && rd) ? gnt : '0;
      for (int k = 1; k <= RD_LAT; k++) tag[k] <= tag[k-1];
      bcast_xfc <= tag[RD_LAT];
      if (|tag[RD_LAT]) bcast_data <= mem_rdata;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single framebuffer/memory port between NUM_REQ drawing engines, such as the fill-rect engine and future line/blit engines. Each engine presents an rts/rtr request carrying addr, data, byte-enables and op. The block grants one request per cycle, round-robin, and drives a registered memory command. Read data returns on a shared broadcast bus, with a per-requester transfer-complete strobe marking its owner.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
ADDR_W, 16, address width
DATA_W, 32, data width
RD_LAT, 2, memory read latency in cycles from mem command to mem_rdata valid (1..4)

Ports:
clk  in  1  clock
rst_  in  1  reset, asynchronous, active-low
req_rts  in  NUM_REQ  per-requester ready-to-send
req_rtr  out  NUM_REQ  per-requester ready-to-receive (grant)
req_op  in  NUM_REQ  per-requester op: 0 = write, 1 = read
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed write data
req_wben  in  NUM_REQ*DATA_W/8  packed byte write enables
mem_en  out  1  memory command valid
mem_we  out  1  1 = write command
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wben  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data
bcast_data  out  DATA_W  read data broadcast to all requesters
bcast_xfc  out  NUM_REQ  one-hot read-complete strobe, owner of bcast_data

Behaviour:
- Reset values: req_rtr=0 while rst_ low; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wben=0, bcast_data=0, bcast_xfc=0; rr_ptr=0; tag pipeline cleared.
- Grant logic is combinational:
  - Search req_rts starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set requester wins, and only the winner gets req_rtr high.
  - req_rtr never asserts without the matching req_rts.
  - A transfer occurs when req_rts[i] & req_rtr[i]. At most one transfer per cycle.
- rr_ptr update:
  - On a transfer by requester w, rr_ptr <= (w+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds.
  - Wrap: w = NUM_REQ-1 gives rr_ptr = 0.
- Memory command:
  - Accepted at edge T, driven registered during cycle T+1: mem_en=1, mem_we=~op, and addr/wdata/wben copied from the winner.
  - With no transfer, mem_en=0 and the other mem_* outputs hold.
  - A write with wben=0 still consumes a slot and issues mem_en=1, mem_we=1, mem_wben=0.
- Read return:
  - A read accepted at T pushes a one-hot owner tag into a shift pipeline of depth RD_LAT+1.
  - mem_rdata is sampled at cycle T+1+RD_LAT.
  - In cycle T+2+RD_LAT: bcast_data = that data and bcast_xfc = owner one-hot. Read latency is RD_LAT+2 cycles.
  - Writes push a zero tag and generate no bcast_xfc.
  - bcast_data holds its last value when bcast_xfc=0.
- Throughput: back-to-back reads, one per cycle, are supported; bcast_xfc then asserts on consecutive cycles. Return order equals issue order.
- Simultaneous events: a read return and a new grant in the same cycle are independent.
- Requester rules: a requester must hold rts, op, addr, data and wben stable until it transfers. Dropping rts without a transfer is allowed and removes it from arbitration that cycle.
- Reset mid-operation: in-flight read tags are discarded and no bcast_xfc is produced for them. The memory sees mem_en=0 from reset onward.

Decomposition:
- Shared package/header:
  - op encoding constants OP_WRITE=0, OP_READ=1
  - default widths ADDR_W/DATA_W shared with all drawing engines
- One sub-module: rr_arbiter (NUM_REQ rts vector + rr_ptr in, one-hot grant + winner index out), reusable for a later command-dispatch arbiter.
- The tag shift pipeline and the mem/bcast registers stay in mem_port_arbiter.

Test Plan:
1. Single write:
   - Stimulus: req0 rts, op=0, addr=0x0010, data=0xA5A5_0F0F, wben=0xF.
   - Required: req_rtr[0]=1 the same cycle; next cycle mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0xA5A5_0F0F; no bcast_xfc ever.
2. Read latency (RD_LAT=2):
   - Stimulus: req2 read addr=0x0100; memory model returns 0x1234_5678.
   - Required: bcast_xfc=4'b0100 and bcast_data=0x1234_5678 exactly 4 cycles after the transfer; bcast_xfc is 1 cycle wide.
3. Fairness:
   - Stimulus: all 4 requesters hold rts continuously for 8 cycles, starting from rr_ptr=0.
   - Required: grant sequence 0,1,2,3,0,1,2,3; no requester waits more than 3 cycles.
4. Wrap and skip:
   - Stimulus: rr_ptr=3, rts=4'b0011.
   - Required: grant 0, then 1, then rr_ptr=2.
5. Back-to-back reads:
   - Stimulus: req1 issues reads 0x20, 0x21, then req3 issues read 0x22 on consecutive cycles.
   - Required: bcast_xfc = 0010, 0010, 1000 on consecutive cycles, with data in issue order.
6. Reset mid-flight:
   - Stimulus: assert rst_ low one cycle after a read transfer, then release.
   - Required: all outputs 0 immediately; no bcast_xfc after release; the next grant starts from requester 0.
